// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS execute stage.
//   - Bus widths for the ID->EX, EX->MEM and EX->ID buses.
//   - Stall vector width and the STOP / NO_STOP levels.
//   - alu_op, md_op and mem_op encodings, plus the load read-enable encoding.
//   - Packed layouts of the three pipeline buses.
// The ID->EX bus carries no separate sel_rf_res field; the stage derives it
// from mem_op, so bits [95:64] are entirely src1.
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 144;
  localparam int unsigned EX_TO_MEM_WD = 80;
  localparam int unsigned EX_TO_ID_WD  = 39;
  localparam int unsigned STALL_BUS_WD = 6;
  localparam int unsigned DIV_CYCLES   = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLT   = 4'd2,
    ALU_SLTU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MFHI  = 4'd12,
    ALU_MFLO  = 4'd13,
    ALU_PASS2 = 4'd14
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_DIV   = 3'd1,
    MD_DIVU  = 3'd2,
    MD_MULT  = 3'd3,
    MD_MULTU = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LB   = 3'd2,
    MEM_LBU  = 3'd3,
    MEM_SW   = 3'd4,
    MEM_SB   = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Word loads enable all lanes; byte loads (signed or not) enable one lane.
  localparam logic [3:0] READEN_WORD = 4'b1111;
  localparam logic [3:0] READEN_NONE = 4'b0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic [2:0]  mem_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
  } id_to_ex_t;

  typedef struct packed {
    logic [3:0]  data_ram_readen;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic        ex_is_load;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_id_t;

  function automatic logic [3:0] lane_onehot(input logic [1:0] addr_lo);
    return 4'b0001 << addr_lo;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter32.sv
// div_iter32: iterative restoring divider, one quotient bit per cycle.
//   clk, rst    : clock, synchronous active-high reset (discards any division)
//   start       : begin a division when idle (operands sampled this cycle)
//   is_signed   : treat operands as two's complement
//   dividend    : 32-bit dividend
//   divisor     : 32-bit divisor
//   ack         : consumer took the result; leave DONE
//   busy        : stall request (start cycle plus every iteration cycle)
//   done        : result valid and held until ack
//   quotient    : signed/unsigned quotient (all ones on divide by zero)
//   remainder   : remainder with the dividend's sign
module div_iter32
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        div_zero_q;
  logic [32:0] diff;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB. A set diff[32] means the
  // trial subtraction borrowed (partial remainder < divisor).
  always_comb begin
    diff = {rem_q, quo_q[31]} - {1'b0, dsr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem_q      <= '0;
            quo_q      <= magnitude(dividend, is_signed);
            dsr_q      <= magnitude(divisor, is_signed);
            cnt_q      <= '0;
            neg_quo_q  <= is_signed && (dividend[31] ^ divisor[31]);
            neg_rem_q  <= is_signed && dividend[31];
            div_zero_q <= (divisor == '0);
            state      <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= {rem_q[30:0], quo_q[31]};
            quo_q <= {quo_q[30:0], 1'b0};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_CYCLES - 1)) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == DIV_BUSY) || ((state == DIV_IDLE) && start);
    done = (state == DIV_DONE);
    // With a zero divisor every trial "succeeds" and the remainder register
    // ends up holding |dividend|, so only the quotient needs forcing.
    if (div_zero_q) begin
      quotient = '1;
    end else begin
      quotient = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    end
    remainder = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline (between ID and MEM).
//   clk, rst         : clock, synchronous active-high reset
//   stall            : stall vector; bit 2 = EX, bit 3 = MEM
//   id_to_ex_bus     : decoded instruction from ID
//   ex_to_mem_bus    : result and memory-access info for MEM
//   ex_to_id_bus     : forwarding bus back to ID
//   data_sram_en     : data SRAM enable
//   data_sram_wen    : byte write enables
//   data_sram_addr   : byte address (= ALU result)
//   data_sram_wdata  : store data, byte-replicated for SB
//   stallreq_for_ex  : stall request while the divider is working
// Build option: define EX_MULT_EN for single-cycle MULT/MULTU; without it
// those md_op codes leave HI/LO untouched.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   ex_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [3:0]  lane;
  logic [3:0]  readen;
  logic        div_start;
  logic        div_signed;
  logic        div_ack;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  ex_to_mem_t  mem_out;
  ex_to_id_t   id_out;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // EX stopped while MEM runs inserts a bubble; otherwise a stopped EX holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      ex_q <= '0;
    end else if (stall[2] == NO_STOP) begin
      ex_q <= id_to_ex_bus;
    end
  end

  always_comb begin
    ex_result = '0;
    case (ex_q.alu_op)
      ALU_ADD:   ex_result = ex_q.src1 + ex_q.src2;
      ALU_SUB:   ex_result = ex_q.src1 - ex_q.src2;
      ALU_SLT:   ex_result = {31'b0, $signed(ex_q.src1) < $signed(ex_q.src2)};
      ALU_SLTU:  ex_result = {31'b0, ex_q.src1 < ex_q.src2};
      ALU_AND:   ex_result = ex_q.src1 & ex_q.src2;
      ALU_OR:    ex_result = ex_q.src1 | ex_q.src2;
      ALU_XOR:   ex_result = ex_q.src1 ^ ex_q.src2;
      ALU_NOR:   ex_result = ~(ex_q.src1 | ex_q.src2);
      ALU_SLL:   ex_result = ex_q.src2 << ex_q.src1[4:0];
      ALU_SRL:   ex_result = ex_q.src2 >> ex_q.src1[4:0];
      ALU_SRA:   ex_result = $unsigned($signed(ex_q.src2) >>> ex_q.src1[4:0]);
      ALU_LUI:   ex_result = {ex_q.src2[15:0], 16'b0};
      ALU_MFHI:  ex_result = hi_q;
      ALU_MFLO:  ex_result = lo_q;
      ALU_PASS2: ex_result = ex_q.src2;
      default:   ex_result = '0;
    endcase
  end

  always_comb begin
    lane            = lane_onehot(ex_result[1:0]);
    ex_is_load      = (ex_q.mem_op == MEM_LW) || (ex_q.mem_op == MEM_LB) ||
                      (ex_q.mem_op == MEM_LBU);
    data_sram_en    = (ex_q.mem_op != MEM_NONE);
    data_sram_addr  = ex_result;
    data_sram_wen   = '0;
    data_sram_wdata = '0;
    readen          = READEN_NONE;
    case (ex_q.mem_op)
      MEM_LW:  readen = READEN_WORD;
      MEM_LB:  readen = lane;
      MEM_LBU: readen = lane;
      MEM_SW: begin
        data_sram_wen   = '1;
        data_sram_wdata = ex_q.store_data;
      end
      MEM_SB: begin
        data_sram_wen   = lane;
        data_sram_wdata = {4{ex_q.store_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_out.data_ram_readen = readen;
    mem_out.pc              = ex_q.pc;
    mem_out.data_ram_en     = data_sram_en;
    mem_out.data_ram_wen    = data_sram_wen;
    mem_out.sel_rf_res      = ex_is_load;
    mem_out.rf_we           = ex_q.rf_we;
    mem_out.rf_waddr        = ex_q.rf_waddr;
    mem_out.ex_result       = ex_result;
    id_out.ex_is_load       = ex_is_load;
    id_out.rf_we            = ex_q.rf_we;
    id_out.rf_waddr         = ex_q.rf_waddr;
    id_out.ex_result        = ex_result;
    ex_to_mem_bus           = mem_out;
    ex_to_id_bus            = id_out;
  end

  assign div_start       = (ex_q.md_op == MD_DIV) || (ex_q.md_op == MD_DIVU);
  assign div_signed      = (ex_q.md_op == MD_DIV);
  assign div_ack         = (stall[2] == NO_STOP);
  assign stallreq_for_ex = div_busy;

  div_iter32 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
    .dividend  (ex_q.src1),
    .divisor   (ex_q.src2),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef EX_MULT_EN
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  always_comb begin
    prod_s = {{32{ex_q.src1[31]}}, ex_q.src1} * {{32{ex_q.src2[31]}}, ex_q.src2};
    prod_u = {32'b0, ex_q.src1} * {32'b0, ex_q.src2};
  end
`endif

  // HI/LO only change on an edge where EX advances; a finished division
  // holds its result in the divider until that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (stall[2] == NO_STOP) begin
      if (div_done) begin
        lo_q <= div_quo;
        hi_q <= div_rem;
      end else begin
        case (ex_q.md_op)
          MD_MTHI: hi_q <= ex_q.src1;
          MD_MTLO: lo_q <= ex_q.src1;
`ifdef EX_MULT_EN
          MD_MULT:  {hi_q, lo_q} <= prod_s;
          MD_MULTU: {hi_q, lo_q} <= prod_u;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;

  typedef struct {
    logic [31:0] pc;
    int unsigned alu;
    int unsigned md;
    int unsigned mem;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] sd;
  } ins_t;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [143:0] id_to_ex_bus;
  logic [79:0]  ex_to_mem_bus;
  logic [38:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  int errors = 0;
  int checks = 0;

  // reference state: instruction resident in EX, HI/LO, pending divide result
  ins_t        cur;
  ins_t        nxt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_pend;
  logic [31:0] div_q;
  logic [31:0] div_r;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic ins_t nop();
    ins_t i;
    i.pc = '0; i.alu = 0; i.md = 0; i.mem = 0; i.we = 1'b0; i.wa = '0;
    i.s1 = '0; i.s2 = '0; i.sd = '0;
    return i;
  endfunction

  function automatic logic [143:0] pack(ins_t i);
    return {i.pc, 4'(i.alu), 3'(i.md), 3'(i.mem), i.we, i.wa, i.s1, i.s2, i.sd};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(ins_t i);
    int sa;
    case (i.alu)
      0:  return i.s1 + i.s2;
      1:  return i.s1 - i.s2;
      2:  return ($signed(i.s1) < $signed(i.s2)) ? 32'd1 : 32'd0;
      3:  return (i.s1 < i.s2) ? 32'd1 : 32'd0;
      4:  return i.s1 & i.s2;
      5:  return i.s1 | i.s2;
      6:  return i.s1 ^ i.s2;
      7:  return ~(i.s1 | i.s2);
      8:  return i.s2 << i.s1[4:0];
      9:  return i.s2 >> i.s1[4:0];
      10: begin sa = int'(i.s2); sa = sa >>> i.s1[4:0]; return 32'(sa); end
      11: return {i.s2[15:0], 16'h0};
      12: return hi;
      13: return lo;
      14: return i.s2;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic exp_stallreq);
    logic [31:0] res;
    logic [3:0]  lane, wen, readen;
    logic [31:0] wdata;
    logic        ld, en;
    res    = alu_model(cur);
    lane   = 4'b0001 << res[1:0];
    ld     = (cur.mem >= 1) && (cur.mem <= 3);
    en     = (cur.mem != 0);
    wen    = (cur.mem == 4) ? 4'hF : (cur.mem == 5) ? lane : 4'h0;
    wdata  = (cur.mem == 4) ? cur.sd : (cur.mem == 5) ? {4{cur.sd[7:0]}} : 32'h0;
    readen = (cur.mem == 1) ? 4'hF : ld ? lane : 4'h0;
    chk("ex_to_mem", ex_to_mem_bus,
        {readen, cur.pc, en, wen, ld, cur.we, cur.wa, res});
    chk("ex_to_id", ex_to_id_bus, {ld, cur.we, cur.wa, res});
    chk("sram_en", data_sram_en, en);
    chk("sram_wen", data_sram_wen, wen);
    chk("sram_addr", data_sram_addr, res);
    chk("sram_wdata", data_sram_wdata, wdata);
    chk("stallreq", stallreq_for_ex, exp_stallreq);
  endtask

  task automatic set_id(input ins_t i);
    nxt = i;
    id_to_ex_bus = pack(i);
  endtask

  // advance reference model across the coming edge, then wait for it
  task automatic tick();
    if (rst) begin
      cur = nop(); hi = '0; lo = '0; div_pend = 1'b0;
    end else if (!stall[2]) begin
      if (div_pend) begin
        lo = div_q; hi = div_r; div_pend = 1'b0;
      end else if (cur.md == 5) hi = cur.s1;
      else if (cur.md == 6) lo = cur.s1;
`ifdef EX_MULT_EN
      else if (cur.md == 3) {hi, lo} = longint'($signed(cur.s1)) * longint'($signed(cur.s2));
      else if (cur.md == 4) {hi, lo} = {32'h0, cur.s1} * {32'h0, cur.s2};
`endif
      cur = nxt;
    end else if (!stall[3]) begin
      cur = nop();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ins_t i);
    set_id(i);
    stall = 6'b000000;
    tick();
  endtask

  function automatic ins_t mk(int unsigned alu, int unsigned md, int unsigned mem,
                              logic [31:0] s1, logic [31:0] s2, logic [31:0] sd);
    ins_t i;
    i = nop();
    i.pc = $urandom; i.alu = alu; i.md = md; i.mem = mem;
    i.we = 1'($urandom_range(0, 1)); i.wa = 5'($urandom_range(0, 31));
    i.s1 = s1; i.s2 = s2; i.sd = sd;
    return i;
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned hold);
    int n;
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    issue(mk(0, sgn ? 1 : 2, 0, a, b, 32'h0));
    div_q = q; div_r = r; div_pend = 1'b1;
    n = 0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      stall = 6'b001111;
      tick();
    end
    chk("div_stall_cycles", 32'(n), 32'd33);
    check_all(1'b0);
    for (int k = 0; k < int'(hold); k++) begin
      stall = 6'b001111;
      tick();
      check_all(1'b0);
    end
    issue(mk(13, 0, 0, $urandom, $urandom, 32'h0));
    check_all(1'b0);
    chk("div_lo", ex_to_id_bus[31:0], q);
    issue(mk(12, 0, 0, $urandom, $urandom, 32'h0));
    check_all(1'b0);
    chk("div_hi", ex_to_id_bus[31:0], r);
  endtask

  initial begin
    ins_t r;
    int   n;
    cur = nop(); nxt = nop(); hi = '0; lo = '0; div_pend = 1'b0;
    div_q = '0; div_r = '0;
    rst = 1'b1; stall = 6'b000000; id_to_ex_bus = '0;
    tick();
    tick();
    check_all(1'b0);
    chk("reset_mem_bus", ex_to_mem_bus, 80'h0);
    rst = 1'b0;

    // ADD wrap into the sign bit
    issue(mk(0, 0, 0, 32'h7FFF_FFFF, 32'h1, 32'h0));
    check_all(1'b0);
    chk("add_result", ex_to_id_bus[31:0], 32'h8000_0000);

    // SB to lane 3
    issue(mk(0, 0, 5, 32'h1000, 32'h3, 32'hAB));
    check_all(1'b0);
    chk("sb_wen", data_sram_wen, 4'b1000);
    chk("sb_addr", data_sram_addr, 32'h1003);
    chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);

    // bubble with LW resident, then reload once the stall clears
    issue(mk(0, 0, 1, 32'h2000, 32'h4, 32'h0));
    check_all(1'b0);
    set_id(mk(6, 0, 4, $urandom, $urandom, $urandom));
    stall = 6'b000111;
    tick();
    check_all(1'b0);
    chk("bubble_mem_bus", ex_to_mem_bus, 80'h0);
    stall = 6'b000000;
    tick();
    check_all(1'b0);

    // divider: directed cases, hold in DONE, random operands
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0);
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 3);
    for (int k = 0; k < 6; k++) begin
      run_div(1'($urandom_range(0, 1)), rnd_word(), rnd_word(), $urandom_range(0, 2));
    end

    // reset in the middle of a division
    issue(mk(0, 1, 0, 32'h1234_5678, 32'd7, 32'h0));
    n = 0;
    for (int k = 0; k < 11; k++) begin
      if (stallreq_for_ex === 1'b1) n++;
      stall = 6'b001111;
      tick();
    end
    chk("busy_before_rst", 32'(n), 32'd11);
    set_id(mk(12, 0, 0, $urandom, $urandom, 32'h0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all(1'b0);
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    stall = 6'b000000;
    tick();
    check_all(1'b0);
    chk("rst_hi", ex_to_id_bus[31:0], 32'h0);
    issue(mk(13, 0, 0, $urandom, $urandom, 32'h0));
    check_all(1'b0);
    chk("rst_lo", ex_to_id_bus[31:0], 32'h0);

    // random instruction stream with random stall patterns
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: r = mk($urandom_range(0, 15), 5, $urandom_range(0, 5), rnd_word(), rnd_word(), rnd_word());
        1: r = mk($urandom_range(0, 15), 6, $urandom_range(0, 5), rnd_word(), rnd_word(), rnd_word());
        2: r = mk($urandom_range(0, 15), $urandom_range(3, 4), $urandom_range(0, 5), rnd_word(), rnd_word(), rnd_word());
        default: r = mk($urandom_range(0, 15), 0, $urandom_range(0, 5), rnd_word(), rnd_word(), rnd_word());
      endcase
      set_id(r);
      case ($urandom_range(0, 5))
        0: stall = 6'b001111;
        1: stall = 6'b000111;
        default: stall = 6'b000000;
      endcase
      tick();
      check_all(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
